// File: rtl/gray_count_decoder_pkg.sv
// Shared definitions for the Gray count decoder and its companion Gray counter:
// control state encodings and the Gray-to-binary conversion.
package gray_count_decoder_pkg;

    localparam logic [1:0] ST_NOBASE = 2'd0;
    localparam logic [1:0] ST_BASE   = 2'd1;
    localparam logic [1:0] ST_TRACK  = 2'd2;

    // Widest count the shared conversion supports; narrower counts are zero-extended.
    localparam int GRAY_MAX_W = 32;

    function automatic logic [GRAY_MAX_W-1:0] gray_to_bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_count_decoder_gray2bin.sv
// Combinational Gray-to-binary converter for a COUNTER_WIDTH-bit count.
module gray2bin
    import gray_count_decoder_pkg::*;
#(
    parameter int COUNTER_WIDTH = 2
) (
    input  logic [COUNTER_WIDTH-1:0] gray,
    output logic [COUNTER_WIDTH-1:0] bin
);

    // Zero-extended leading Gray bits decode to zero, so truncation is exact.
    assign bin = COUNTER_WIDTH'(gray_to_bin(GRAY_MAX_W'(gray)));

endmodule

// File: rtl/gray_count_decoder.sv
// Two-stage decoder: captures qualified Gray samples, then reports the binary value,
// the step from the previous sample, a saturating running total and a sticky error.
module gray_count_decoder
    import gray_count_decoder_pkg::*;
#(
    parameter int COUNTER_WIDTH = 2,
    parameter int ACC_WIDTH     = 16
) (
    input  logic                     Clk,
    input  logic                     Clear_in,
    input  logic [COUNTER_WIDTH-1:0] GrayCount_in,
    input  logic                     Sample_in,
    output logic [COUNTER_WIDTH-1:0] BinaryCount_out,
    output logic [COUNTER_WIDTH-1:0] Delta_out,
    output logic [ACC_WIDTH-1:0]     Total_out,
    output logic                     Valid_out,
    output logic                     Error_out
);

    function automatic logic [ACC_WIDTH-1:0] sat_add(input logic [ACC_WIDTH-1:0] acc,
                                                     input logic [COUNTER_WIDTH-1:0] step);
        logic [ACC_WIDTH:0] sum;
        sum = {1'b0, acc} + (ACC_WIDTH+1)'(step);
        return sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
    endfunction

    logic [1:0]               state;
    logic                     vld_p1;
    logic [COUNTER_WIDTH-1:0] gray_p1;
    logic [COUNTER_WIDTH-1:0] gray_prev;
    logic [COUNTER_WIDTH-1:0] bin_p1;
    logic [COUNTER_WIDTH-1:0] delta_p1;
    logic [COUNTER_WIDTH-1:0] diff_p1;
    logic                     multi_bit_p1;

    gray2bin #(
        .COUNTER_WIDTH(COUNTER_WIDTH)
    ) u_gray2bin (
        .gray(gray_p1),
        .bin (bin_p1)
    );

    // BinaryCount_out doubles as the previous binary sample.
    assign delta_p1     = bin_p1 - BinaryCount_out;
    assign diff_p1      = gray_p1 ^ gray_prev;
    assign multi_bit_p1 = |(diff_p1 & (diff_p1 - COUNTER_WIDTH'(1)));

    always_ff @(posedge Clk) begin
        if (Clear_in) begin
            state           <= ST_NOBASE;
            vld_p1          <= 1'b0;
            gray_p1         <= '0;
            gray_prev       <= '0;
            BinaryCount_out <= '0;
            Delta_out       <= '0;
            Total_out       <= '0;
            Valid_out       <= 1'b0;
            Error_out       <= 1'b0;
        end else begin
            // Stage 1: capture the qualified Gray sample
            vld_p1 <= Sample_in;
            if (Sample_in) begin
                gray_p1 <= GrayCount_in;
            end

            // Stage 2: decode, difference, accumulate
            Valid_out <= vld_p1;
            if (vld_p1) begin
                BinaryCount_out <= bin_p1;
                gray_prev       <= gray_p1;
                if (state == ST_NOBASE) begin
                    Delta_out <= '0;
                    state     <= ST_BASE;
                end else begin
                    Delta_out <= delta_p1;
                    Total_out <= sat_add(Total_out, delta_p1);
                    if (multi_bit_p1) begin
                        Error_out <= 1'b1;
                    end
                    state <= ST_TRACK;
                end
            end
        end
    end

endmodule

// File: tb/tb_gray_count_decoder.sv
// Scoreboard bench: directed Gray vectors with hand-computed results, checked by monitors.
module tb_gray_count_decoder;

    typedef struct {
        int          cyc;
        logic [3:0]  bin;
        logic [3:0]  delta;
        logic [15:0] total;
        logic        err;
    } exp_t;

    logic        Clk;
    int          cyc;
    int          checks;
    int          errors;

    // Instance A: 4-bit count, 4-bit accumulator (saturates quickly)
    logic        a_clear, a_sample, a_valid, a_err;
    logic [3:0]  a_gray, a_bin, a_delta, a_total;
    // Instance B: 2-bit count, default 16-bit accumulator
    logic        b_clear, b_sample, b_valid, b_err;
    logic [1:0]  b_gray, b_bin, b_delta;
    logic [15:0] b_total;

    exp_t qa[$];
    exp_t qb[$];
    exp_t last_a, last_b, ea, eb;
    bit   armed_a, armed_b;

    gray_count_decoder #(.COUNTER_WIDTH(4), .ACC_WIDTH(4)) dut_a (
        .Clk(Clk), .Clear_in(a_clear), .GrayCount_in(a_gray), .Sample_in(a_sample),
        .BinaryCount_out(a_bin), .Delta_out(a_delta), .Total_out(a_total),
        .Valid_out(a_valid), .Error_out(a_err)
    );

    gray_count_decoder #(.COUNTER_WIDTH(2), .ACC_WIDTH(16)) dut_b (
        .Clk(Clk), .Clear_in(b_clear), .GrayCount_in(b_gray), .Sample_in(b_sample),
        .BinaryCount_out(b_bin), .Delta_out(b_delta), .Total_out(b_total),
        .Valid_out(b_valid), .Error_out(b_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitors: pop on every Valid_out, otherwise outputs must hold their last values.
    always @(negedge Clk) begin
        if (armed_a) begin
            if (a_valid === 1'b1) begin
                if (qa.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_unexpected_valid actual=1 required=0 cycle=%0d", cyc);
                end else begin
                    ea = qa.pop_front();
                    chk("a_latency", cyc, ea.cyc);
                    chk("a_bin", 32'(a_bin), 32'(ea.bin));
                    chk("a_delta", 32'(a_delta), 32'(ea.delta));
                    chk("a_total", 32'(a_total), 32'(ea.total));
                    chk("a_err", 32'(a_err), 32'(ea.err));
                    last_a = ea;
                end
            end else begin
                chk("a_hold_valid", 32'(a_valid), 32'(0));
                chk("a_hold_bin", 32'(a_bin), 32'(last_a.bin));
                chk("a_hold_delta", 32'(a_delta), 32'(last_a.delta));
                chk("a_hold_total", 32'(a_total), 32'(last_a.total));
                chk("a_hold_err", 32'(a_err), 32'(last_a.err));
            end
        end
    end

    always @(negedge Clk) begin
        if (armed_b) begin
            if (b_valid === 1'b1) begin
                if (qb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected_valid actual=1 required=0 cycle=%0d", cyc);
                end else begin
                    eb = qb.pop_front();
                    chk("b_latency", cyc, eb.cyc);
                    chk("b_bin", 32'(b_bin), 32'(eb.bin));
                    chk("b_delta", 32'(b_delta), 32'(eb.delta));
                    chk("b_total", 32'(b_total), 32'(eb.total));
                    chk("b_err", 32'(b_err), 32'(eb.err));
                    last_b = eb;
                end
            end else begin
                chk("b_hold_valid", 32'(b_valid), 32'(0));
                chk("b_hold_bin", 32'(b_bin), 32'(last_b.bin));
                chk("b_hold_total", 32'(b_total), 32'(last_b.total));
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // Clear, optionally with a competing sample in the same cycle.
    task automatic clear_a(input bit with_sample, input logic [3:0] g);
        a_clear  = 1'b1;
        a_sample = with_sample;
        a_gray   = g;
        step();
        a_clear  = 1'b0;
        a_sample = 1'b0;
        qa.delete();
        last_a   = '{0, 4'd0, 4'd0, 16'd0, 1'b0};
        armed_a  = 1'b1;
    endtask

    task automatic sample_a(input logic [3:0] g, input logic [3:0] bin, input logic [3:0] delta,
                            input logic [3:0] total, input logic err);
        a_gray   = g;
        a_sample = 1'b1;
        qa.push_back('{cyc + 2, bin, delta, 16'(total), err});
        step();
        a_sample = 1'b0;
    endtask

    task automatic sample_b(input logic [1:0] g, input logic [1:0] bin, input logic [1:0] delta,
                            input logic [15:0] total);
        b_gray   = g;
        b_sample = 1'b1;
        qb.push_back('{cyc + 2, 4'(bin), 4'(delta), total, 1'b0});
        step();
        b_sample = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0;
        armed_a = 1'b0; armed_b = 1'b0;
        a_clear = 1'b0; a_sample = 1'b0; a_gray = '0;
        b_clear = 1'b0; b_sample = 1'b0; b_gray = '0;
        idle(2);

        // Basic count sequence, back-to-back, then a repeated sample
        clear_a(1'b0, 4'b0000);
        idle(2);
        sample_a(4'b0000, 4'd0, 4'd0, 4'd0, 1'b0);
        sample_a(4'b0001, 4'd1, 4'd1, 4'd1, 1'b0);
        sample_a(4'b0011, 4'd2, 4'd1, 4'd2, 1'b0);
        sample_a(4'b0010, 4'd3, 4'd1, 4'd3, 1'b0);
        sample_a(4'b0010, 4'd3, 4'd0, 4'd3, 1'b0);
        idle(3);

        // Illegal two-bit jump; error sticks through legal samples until clear.
        // The sample competing with this clear must be dropped.
        clear_a(1'b1, 4'b0101);
        sample_a(4'b0000, 4'd0, 4'd0, 4'd0, 1'b0);
        sample_a(4'b0011, 4'd2, 4'd2, 4'd2, 1'b1);
        sample_a(4'b0010, 4'd3, 4'd1, 4'd3, 1'b1);
        sample_a(4'b0110, 4'd4, 4'd1, 4'd4, 1'b1);
        idle(3);

        // Saturation of the 4-bit total and 15 -> 0 wrap
        clear_a(1'b0, 4'b0000);
        sample_a(4'b0000, 4'd0,  4'd0,  4'd0,  1'b0);
        sample_a(4'b1000, 4'd15, 4'd15, 4'd15, 1'b0);
        sample_a(4'b0000, 4'd0,  4'd1,  4'd15, 1'b0);
        sample_a(4'b1000, 4'd15, 4'd15, 4'd15, 1'b0);
        idle(3);

        // Clear one cycle after a sample: that sample is lost, next one rebases
        clear_a(1'b0, 4'b0000);
        a_gray = 4'b0001; a_sample = 1'b1;
        step();
        clear_a(1'b0, 4'b0000);
        sample_a(4'b0011, 4'd2, 4'd0, 4'd0, 1'b0);
        sample_a(4'b0010, 4'd3, 4'd1, 4'd1, 1'b0);
        idle(3);

        // Gapped samples; last step backwards is delta 15 and saturates
        clear_a(1'b0, 4'b0000);
        sample_a(4'b0000, 4'd0, 4'd0, 4'd0, 1'b0);
        idle(3);
        sample_a(4'b0001, 4'd1, 4'd1, 4'd1, 1'b0);
        idle(3);
        sample_a(4'b0011, 4'd2, 4'd1, 4'd2, 1'b0);
        idle(3);
        sample_a(4'b0001, 4'd1, 4'd15, 4'd15, 1'b0);
        idle(4);

        // 2-bit full cycle with wrap 3 -> 0
        b_clear = 1'b1;
        step();
        b_clear = 1'b0;
        last_b  = '{0, 4'd0, 4'd0, 16'd0, 1'b0};
        armed_b = 1'b1;
        sample_b(2'b00, 2'd0, 2'd0, 16'd0);
        sample_b(2'b01, 2'd1, 2'd1, 16'd1);
        sample_b(2'b11, 2'd2, 2'd1, 16'd2);
        sample_b(2'b10, 2'd3, 2'd1, 16'd3);
        sample_b(2'b00, 2'd0, 2'd1, 16'd4);
        idle(4);

        chk("a_pending_at_end", 32'(qa.size()), 32'(0));
        chk("b_pending_at_end", 32'(qb.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gray_count_decoder.md
GRAY_COUNT_DECODER -- requirements
Module: gray_count_decoder

Interface
REQ-001 Parameter COUNTER_WIDTH, default 2, is the width of the Gray count being decoded; legal range is 2 or more.
REQ-002 Parameter ACC_WIDTH, default 16, is the width of the running event accumulator; legal range is COUNTER_WIDTH or more.
REQ-003 Clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Clear_in  input  1  is the reset: synchronous, active-high.
REQ-005 GrayCount_in  input  COUNTER_WIDTH  carries the Gray-coded count from the companion Gray counter, already in the Clk domain.
REQ-006 Sample_in  input  1  qualifies GrayCount_in for capture in that cycle.
REQ-007 BinaryCount_out  output  COUNTER_WIDTH  is the binary equivalent of the last accepted sample.
REQ-008 Delta_out  output  COUNTER_WIDTH  is the binary step from the previous accepted sample, modulo 2^COUNTER_WIDTH.
REQ-009 Total_out  output  ACC_WIDTH  is the saturating sum of all Delta values since reset.
REQ-010 Valid_out  output  1  is a one-cycle pulse marking BinaryCount_out, Delta_out and Total_out as updated.
REQ-011 Error_out  output  1  is a sticky flag for an illegal Gray transition (more than one bit changed between consecutive accepted samples).

Function
REQ-012 Pipeline: stage 1 SHALL register GrayCount_in when Sample_in=1; stage 2 SHALL register the decoded results.
  - Sample_in high at cycle n -> Valid_out high at cycle n+2.
  - Back-to-back samples SHALL be accepted every cycle with no stall.
REQ-013 Gray-to-binary conversion SHALL be:
  - b[MSB] = g[MSB]
  - b[i] = b[i+1] XOR g[i], for i descending
REQ-014 The control state machine SHALL have three states:
  - NOBASE: after reset.
  - BASE: first sample accepted. The first Valid_out SHALL carry Delta_out=0 and SHALL NOT change Total_out or Error_out.
  - TRACK: entered on the second accepted sample and held until reset.
REQ-015 In TRACK, each Valid_out SHALL carry Delta_out = (bin_now - bin_prev) mod 2^COUNTER_WIDTH.
  - Wrap-around (for example 3 -> 0 at width 2) SHALL yield Delta_out=1.
REQ-016 Total_out SHALL add Delta_out on every TRACK Valid_out and SHALL saturate at all-ones; it SHALL NOT wrap.
REQ-017 Error_out SHALL set when the popcount of (g_now XOR g_prev) is greater than 1 in TRACK.
  - It stays set until Clear_in.
  - The offending sample still updates BinaryCount_out, Delta_out and Total_out.
REQ-018 Repeated identical samples SHALL produce Valid_out with Delta_out=0 and no error.
REQ-019 Sample_in=0 SHALL hold all outputs; Valid_out SHALL be 0.

Reset
REQ-020 Clear_in=1 SHALL set the following at the next edge:
  - state to NOBASE
  - all pipeline registers to 0
  - BinaryCount_out=0, Delta_out=0, Total_out=0
  - Valid_out=0, Error_out=0
REQ-021 Clear_in SHALL take priority over Sample_in in the same cycle.
  - Samples in flight SHALL be discarded.
  - No Valid_out SHALL follow a clear for a sample taken before it.

Structure
REQ-022 A shared package SHALL hold:
  - the state-encoding constants (NOBASE, BASE, TRACK)
  - the gray-to-binary conversion function, shared with the companion Gray counter.
REQ-023 One combinational sub-module, gray2bin, parameterised by COUNTER_WIDTH, SHALL perform the REQ-013 conversion.

Verification
REQ-024 With COUNTER_WIDTH=4, clear, then drive Gray samples 0000, 0001, 0011, 0010 on consecutive cycles:
  - BinaryCount_out = 0, 1, 2, 3
  - Delta_out = 0, 1, 1, 1
  - Total_out = 3, Error_out=0
REQ-025 With COUNTER_WIDTH=2, drive Gray samples 00, 01, 11, 10, 00:
  - final Delta_out=1 (wrap 3->0)
  - Total_out=4
REQ-026 Drive Gray samples 0000 then 0011:
  - Error_out=1 at the second Valid_out, Delta_out=2
  - Error_out stays 1 through later legal samples until Clear_in.
REQ-027 With ACC_WIDTH=4, accumulate deltas past 15: Total_out SHALL stick at 15.
REQ-028 Assert Clear_in one cycle after a sample:
  - no Valid_out for that sample
  - the next sample yields Delta_out=0 (state BASE).
REQ-029 Gap test: Sample_in pulses with 3-cycle gaps SHALL each produce exactly one Valid_out, exactly 2 cycles after the sample.
